// File: rtl/reaction_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : reaction_sequencer
//  Function : Reaction-time game controller: random arm delay, go lamp,
//             tick-based reaction measurement, foul and timeout detection.
//             Optional best-time tracking when REACTION_BEST_EN is defined.
//  Revision : 1.0
// ============================================================================
module reaction_sequencer #(
    parameter int TICK_DIV   = 4,
    parameter int DELAY_MIN  = 3,
    parameter int DELAY_MASK = 15,
    parameter int RT_W       = 10,
    parameter int MAX_RT     = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            button,
    output logic            led,
    output logic            busy,
    output logic [RT_W-1:0] result,
    output logic            result_valid,
`ifdef REACTION_BEST_EN
    output logic [RT_W-1:0] best,
    output logic            best_valid,
`endif
    output logic            foul,
    output logic            timeout
);

    localparam int                 c_PRE_W     = $clog2(TICK_DIV);
    localparam logic [c_PRE_W-1:0] c_TICK_LAST = c_PRE_W'(TICK_DIV - 1);
    localparam logic [15:0]        c_DLY_MIN   = 16'(DELAY_MIN);
    localparam logic [15:0]        c_DLY_MASK  = 16'(DELAY_MASK);
    localparam logic [RT_W-1:0]    c_RT_LAST   = RT_W'(MAX_RT - 1);
    localparam logic [RT_W-1:0]    c_RT_MAX    = RT_W'(MAX_RT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_GO   = 3'd2,
        S_SHOW = 3'd3,
        S_FOUL = 3'd4
    } state_t;

    state_t             r_state,  w_state;
    logic [c_PRE_W-1:0] r_presc,  w_presc;
    logic [15:0]        r_delay,  w_delay;
    logic [RT_W-1:0]    r_rt,     w_rt;
    logic [RT_W-1:0]    r_result, w_result;
    logic               r_led,    w_led;
    logic               r_rv,     w_rv;
    logic               r_foul,   w_foul;
    logic               r_to,     w_to;
    logic [15:0]        r_lfsr;
    logic               r_btn_q;
`ifdef REACTION_BEST_EN
    logic [RT_W-1:0]    r_best,   w_best;
    logic               r_best_v, w_best_v;
`endif

    logic        w_press;
    logic        w_tick;
    logic        w_lfsr_fb;
    logic [15:0] w_dly_load;

    assign w_press    = button & ~r_btn_q;
    assign w_tick     = (r_presc == c_TICK_LAST);
    assign w_lfsr_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_dly_load = c_DLY_MIN + (r_lfsr & c_DLY_MASK);

    always_comb begin
        w_state  = r_state;
        w_delay  = r_delay;
        w_rt     = r_rt;
        w_result = r_result;
        w_led    = r_led;
        w_rv     = r_rv;
        w_foul   = r_foul;
        w_to     = r_to;
`ifdef REACTION_BEST_EN
        w_best   = r_best;
        w_best_v = r_best_v;
`endif
        case (r_state)
            S_IDLE, S_SHOW, S_FOUL: begin
                if (start) begin
                    w_state = S_ARM;
                    w_delay = w_dly_load;
                    w_rv    = 1'b0;
                    w_foul  = 1'b0;
                    w_to    = 1'b0;
                end
            end
            S_ARM: begin
                if (w_press) begin
                    w_state = S_FOUL;
                    w_foul  = 1'b1;
                end else if (w_tick) begin
                    if (r_delay == 16'd1) begin
                        w_state = S_GO;
                        w_rt    = '0;
                        w_led   = 1'b1;
                    end else begin
                        w_delay = r_delay - 16'd1;
                    end
                end
            end
            S_GO: begin
                // A press on a tick cycle reports the count before that tick.
                if (w_press) begin
                    w_state  = S_SHOW;
                    w_result = r_rt;
                    w_rv     = 1'b1;
                    w_led    = 1'b0;
`ifdef REACTION_BEST_EN
                    if (!r_best_v || (r_rt < r_best)) begin
                        w_best   = r_rt;
                        w_best_v = 1'b1;
                    end
`endif
                end else if (w_tick) begin
                    if (r_rt == c_RT_LAST) begin
                        w_state  = S_SHOW;
                        w_result = c_RT_MAX;
                        w_to     = 1'b1;
                        w_rv     = 1'b0;
                        w_led    = 1'b0;
                    end else begin
                        w_rt = r_rt + 1'b1;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
        // Restarting on each state change gives a full tick period after entry.
        w_presc = ((w_state != r_state) || w_tick) ? '0 : r_presc + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_presc  <= '0;
            r_delay  <= '0;
            r_rt     <= '0;
            r_result <= '0;
            r_led    <= 1'b0;
            r_rv     <= 1'b0;
            r_foul   <= 1'b0;
            r_to     <= 1'b0;
            r_lfsr   <= 16'hACE1;
            r_btn_q  <= 1'b0;
`ifdef REACTION_BEST_EN
            r_best   <= '0;
            r_best_v <= 1'b0;
`endif
        end else begin
            r_state  <= w_state;
            r_presc  <= w_presc;
            r_delay  <= w_delay;
            r_rt     <= w_rt;
            r_result <= w_result;
            r_led    <= w_led;
            r_rv     <= w_rv;
            r_foul   <= w_foul;
            r_to     <= w_to;
            r_lfsr   <= {w_lfsr_fb, r_lfsr[15:1]};
            r_btn_q  <= button;
`ifdef REACTION_BEST_EN
            r_best   <= w_best;
            r_best_v <= w_best_v;
`endif
        end
    end

    assign led          = r_led;
    assign busy         = (r_state == S_ARM) || (r_state == S_GO);
    assign result       = r_result;
    assign result_valid = r_rv;
    assign foul         = r_foul;
    assign timeout      = r_to;
`ifdef REACTION_BEST_EN
    assign best         = r_best;
    assign best_valid   = r_best_v;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reaction_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reaction_sequencer
//  Function : Directed and randomized bench for reaction_sequencer with a
//             cycle-level game model.
//  Revision : 1.0
// ============================================================================
module tb_reaction_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int DELAY_MIN  = 3;
    localparam int DELAY_MASK = 15;
    localparam int RT_W       = 10;
    localparam int MAX_RT     = 12;

    logic            clk = 1'b0;
    logic            rst, start, button;
    logic            led, busy, result_valid, foul, timeout;
    logic [RT_W-1:0] result;
`ifdef REACTION_BEST_EN
    logic [RT_W-1:0] best;
    logic            best_valid;
`endif

    reaction_sequencer #(
        .TICK_DIV(TICK_DIV), .DELAY_MIN(DELAY_MIN), .DELAY_MASK(DELAY_MASK),
        .RT_W(RT_W), .MAX_RT(MAX_RT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .button(button),
        .led(led), .busy(busy), .result(result), .result_valid(result_valid),
`ifdef REACTION_BEST_EN
        .best(best), .best_valid(best_valid),
`endif
        .foul(foul), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: phases, elapsed-cycle counts and arithmetic on them.
    localparam int P_IDLE = 0, P_ARM = 1, P_GO = 2, P_DONE = 3;
    int          m_phase, m_n, m_arm_len, m_result, m_best;
    bit          m_led, m_rv, m_foul, m_to, m_bv, m_bq, m_press;
    logic [15:0] m_lfsr;

    always @(posedge clk) begin
        m_press = button && !m_bq;
        if (rst) begin
            m_phase = P_IDLE; m_n = 0; m_arm_len = 0; m_result = 0;
            m_led = 0; m_rv = 0; m_foul = 0; m_to = 0;
            m_best = 0; m_bv = 0; m_bq = 0; m_lfsr = 16'hACE1;
        end else begin
            case (m_phase)
                P_ARM: begin
                    m_n++;
                    if (m_press) begin
                        m_phase = P_DONE; m_foul = 1;
                    end else if (m_n == m_arm_len) begin
                        m_phase = P_GO; m_n = 0; m_led = 1;
                    end
                end
                P_GO: begin
                    m_n++;
                    if (m_press) begin
                        m_phase = P_DONE; m_led = 0; m_rv = 1;
                        m_result = (m_n - 1) / TICK_DIV;
                        if (!m_bv || m_result < m_best) begin
                            m_best = m_result; m_bv = 1;
                        end
                    end else if (m_n == TICK_DIV * MAX_RT) begin
                        m_phase = P_DONE; m_led = 0; m_to = 1; m_result = MAX_RT;
                    end
                end
                default: begin
                    if (start) begin
                        m_phase = P_ARM; m_n = 0;
                        m_arm_len = TICK_DIV * (DELAY_MIN + int'(m_lfsr & 16'(DELAY_MASK)));
                        m_rv = 0; m_foul = 0; m_to = 0;
                    end
                end
            endcase
            m_bq   = button;
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cycle_outputs",
                  {17'd0, led, busy, result, result_valid, foul, timeout},
                  {17'd0, m_led, (m_phase == P_ARM || m_phase == P_GO),
                   RT_W'(m_result), m_rv, m_foul, m_to});
`ifdef REACTION_BEST_EN
            check("cycle_best", {21'd0, best_valid, best}, {21'd0, m_bv, RT_W'(m_best)});
`endif
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_led(output int n);
        n = 0;
        while (!led && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("led_wait", {31'd0, led}, 32'd1);
    endtask

    // Called at the negedge where led is first seen; press sampled on GO cycle k.
    task automatic press_at(input int k);
        repeat (k - 1) @(negedge clk);
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("busy_drop_wait", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int rate;
        rst = 1'b1; start = 1'b0; button = 1'b0;
        @(negedge clk);
        cmp_en = 1;
        check("reset_outputs", {22'd0, led, busy, result, result_valid, foul, timeout}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic round: press on GO cycle 22 -> 5 ticks.
        pulse_start();
        wait_led(n);
        check("arm_len_ticks", n % TICK_DIV, 0);
        check("arm_len_min", {31'd0, n >= 12}, 32'd1);
        check("busy_in_go", {31'd0, busy}, 32'd1);
        press_at(22);
        check("round_result", {22'd0, result}, 32'd5);
        check("round_flags", {29'd0, result_valid, led, busy}, 32'b100);

        // Early press on ARM cycle 5 -> foul.
        repeat (2) @(negedge clk);
        pulse_start();
        repeat (4) @(negedge clk);
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
        check("foul_flags", {28'd0, foul, led, busy, result_valid}, 32'b1000);
        repeat (2) @(negedge clk);
        pulse_start();
        check("restart_clears_foul", {30'd0, foul, busy}, 32'b01);

        // No press -> timeout at MAX_RT.
        wait_led(n);
        wait_idle(TICK_DIV * MAX_RT + 10);
        check("timeout_flag", {30'd0, timeout, result_valid}, 32'b10);
        check("timeout_result", {22'd0, result}, MAX_RT);

        // Button held through GO entry; release then re-press on GO cycle 9.
        button = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start();
        wait_led(n);
        button = 1'b0;
        press_at(9);
        check("held_repress_result", {22'd0, result}, 32'd2);
        check("held_repress_valid", {31'd0, result_valid}, 32'd1);

        // Reset mid-GO with start held high.
        pulse_start();
        wait_led(n);
        start = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midgo_reset", {22'd0, led, busy, result, result_valid, foul, timeout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("start_after_reset", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_led(n);
        press_at(3);

`ifdef REACTION_BEST_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulse_start(); wait_led(n); press_at(29);
        pulse_start(); wait_led(n); press_at(17);
        pulse_start(); wait_led(n); press_at(37);
        check("best_after_rounds", {21'd0, best_valid, best}, {21'd0, 1'b1, 10'd4});
        pulse_start();
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
        check("best_after_foul", {20'd0, foul, best_valid, best}, {20'd0, 2'b11, 10'd4});
`endif

        // Randomized play with varying button activity and rare resets.
        rate = 20;
        for (int i = 0; i < 6000; i++) begin
            if (i % 256 == 0) rate = $urandom_range(3, 80);
            rst   = ($urandom_range(0, 799) == 0);
            start = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, rate - 1) == 0) button = ~button;
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0; button = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
